// File: rtl/pixel_frame_capture_if.sv
// Pixel stream handshake between the frame capture block
// and its downstream consumer.
interface pixel_frame_capture_if #(
   parameter int DATA_W = 8
);
   logic              Pix_valid;
   logic              Pix_ready;
   logic [DATA_W-1:0] Pix_data;
   logic [1:0]        Pix_index;

   modport master (
      output Pix_valid,
      output Pix_data,
      output Pix_index,
      input  Pix_ready
   );

   modport slave (
      input  Pix_valid,
      input  Pix_data,
      input  Pix_index,
      output Pix_ready
   );
endinterface

// File: rtl/pixel_frame_capture.sv
// Captures a 2x2 pixel frame from two row strobes and
// streams the four pixels out over a valid/ready link.
module pixel_frame_capture #(
   parameter int DATA_W = 8
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  NRE_1,
   input  logic                  NRE_2,
   input  logic                  ADC,
   input  logic                  Erase,
   input  logic [DATA_W-1:0]     ADC_1_in,
   input  logic [DATA_W-1:0]     ADC_2_in,
   pixel_frame_capture_if.master pix,
   output logic                  Frame_done,
   output logic                  Overrun,
   output logic                  Row_error
);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      STREAM
   } state_t;

   state_t            state;
   state_t            state_n;
   logic              adc_q;
   logic [3:0]        mask;
   logic [3:0]        mask_n;
   logic [DATA_W-1:0] pix_r [4];
   logic [DATA_W-1:0] pix_n [4];
   logic              strobe;
   logic              row1;
   logic              row2;
   logic              bad;
   logic              hs;
   logic              last;
   logic              erase_ok;
   logic              enter;
   logic [1:0]        nxt;

   assign strobe   = adc_q & ~ADC;
   assign row1     = strobe & ~NRE_1 & NRE_2;
   assign row2     = strobe & NRE_1 & ~NRE_2;
   assign bad      = strobe & (NRE_1 == NRE_2);
   assign hs       = pix.Pix_valid & pix.Pix_ready;
   assign last     = hs & (pix.Pix_index == 2'd3);
   assign erase_ok = Erase & (state != STREAM);
   assign enter    = (state != STREAM) & (state_n == STREAM);
   assign nxt      = pix.Pix_index + 2'd1;

   // State register
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) state <= IDLE;
      else        state <= state_n;
   end

   // Next state, next mask and next pixel store
   always_comb begin
      state_n = state;
      mask_n  = mask;
      pix_n   = pix_r;
      unique case (state)
         IDLE, CAPTURE: begin
            if (Erase) begin
               state_n = IDLE;
               mask_n  = 4'b0000;
            end else begin
               if (row1) begin
                  pix_n[0]    = ADC_1_in;
                  pix_n[1]    = ADC_2_in;
                  mask_n[1:0] = 2'b11;
               end
               if (row2) begin
                  pix_n[2]    = ADC_1_in;
                  pix_n[3]    = ADC_2_in;
                  mask_n[3:2] = 2'b11;
               end
               if (mask == 4'b1111)
                  state_n = STREAM;
               else if (mask_n != 4'b0000)
                  state_n = CAPTURE;
            end
         end
         STREAM: begin
            if (last) begin
               state_n = IDLE;
               mask_n  = 4'b0000;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Strobe edge detector, frame store and sticky flags
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         adc_q     <= 1'b0;
         mask      <= 4'b0000;
         Overrun   <= 1'b0;
         Row_error <= 1'b0;
         for (int i = 0; i < 4; i++) pix_r[i] <= '0;
      end else begin
         adc_q <= ADC;
         mask  <= mask_n;
         pix_r <= pix_n;
         if (erase_ok)
            Overrun <= 1'b0;
         else if ((state == STREAM) && (row1 || row2))
            Overrun <= 1'b1;
         if (erase_ok)
            Row_error <= 1'b0;
         else if (bad)
            Row_error <= 1'b1;
      end
   end

   // Registered stream outputs and end-of-frame pulse
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         pix.Pix_valid <= 1'b0;
         pix.Pix_index <= 2'd0;
         pix.Pix_data  <= '0;
         Frame_done    <= 1'b0;
      end else begin
         Frame_done <= last;
         if (enter) begin
            pix.Pix_valid <= 1'b1;
            pix.Pix_index <= 2'd0;
            pix.Pix_data  <= pix_n[0];
         end else if (last) begin
            pix.Pix_valid <= 1'b0;
            pix.Pix_index <= 2'd0;
            pix.Pix_data  <= '0;
         end else if (hs) begin
            pix.Pix_index <= nxt;
            pix.Pix_data  <= pix_r[nxt];
         end
      end
   end

endmodule

// File: tb/tb_pixel_frame_capture.sv
// Directed bench for pixel_frame_capture with a
// cycle-level frame model and literal spot checks.
module tb_pixel_frame_capture;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       NRE_1 = 1'b1;
   logic       NRE_2 = 1'b1;
   logic       ADC = 1'b0;
   logic       Erase = 1'b0;
   logic [7:0] ADC_1_in = '0;
   logic [7:0] ADC_2_in = '0;
   logic       Frame_done;
   logic       Overrun;
   logic       Row_error;

   int checks = 0;
   int failures = 0;
   logic [7:0] log_q [$];

   pixel_frame_capture_if #(.DATA_W(8)) pif ();

   pixel_frame_capture #(.DATA_W(8)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .NRE_1      (NRE_1),
      .NRE_2      (NRE_2),
      .ADC        (ADC),
      .Erase      (Erase),
      .ADC_1_in   (ADC_1_in),
      .ADC_2_in   (ADC_2_in),
      .pix        (pif),
      .Frame_done (Frame_done),
      .Overrun    (Overrun),
      .Row_error  (Row_error)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Frame model: pixels, captured rows, stream position
   logic [7:0] m_pix [4];
   logic [3:0] m_mask;
   logic       m_adc_prev;
   logic       m_streaming;
   int         m_k;
   logic       e_valid, e_done, e_ovr, e_rerr;
   logic [7:0] e_data;
   logic [1:0] e_index;

   always @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 4; i++) m_pix[i] = 8'h00;
         m_mask = 4'h0;
         m_adc_prev = 1'b0;
         m_streaming = 1'b0;
         m_k = 0;
         e_valid = 0; e_done = 0; e_ovr = 0; e_rerr = 0;
         e_data = 0; e_index = 0;
      end else begin
         logic strobe, hs, go, good;
         strobe = m_adc_prev && !ADC;
         m_adc_prev = ADC;
         hs = e_valid && pif.Pix_ready;
         good = (NRE_1 != NRE_2);
         e_done = 1'b0;
         if (m_streaming) begin
            if (strobe && good) e_ovr = 1'b1;
            if (strobe && !good) e_rerr = 1'b1;
            if (hs) begin
               if (m_k == 3) begin
                  m_streaming = 1'b0;
                  m_mask = 4'h0;
                  e_done = 1'b1;
                  m_k = 0;
               end else begin
                  m_k = m_k + 1;
               end
            end
         end else begin
            go = (m_mask == 4'hf);
            if (Erase) begin
               m_mask = 4'h0;
               e_ovr = 1'b0;
               e_rerr = 1'b0;
            end else begin
               if (strobe && !good) e_rerr = 1'b1;
               if (strobe && !NRE_1 && NRE_2) begin
                  m_pix[0] = ADC_1_in;
                  m_pix[1] = ADC_2_in;
                  m_mask = m_mask | 4'h3;
               end
               if (strobe && NRE_1 && !NRE_2) begin
                  m_pix[2] = ADC_1_in;
                  m_pix[3] = ADC_2_in;
                  m_mask = m_mask | 4'hc;
               end
               if (go) begin
                  m_streaming = 1'b1;
                  m_k = 0;
               end
            end
         end
         e_valid = m_streaming;
         e_index = m_streaming ? 2'(m_k) : 2'd0;
         e_data = m_streaming ? m_pix[m_k] : 8'h00;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge Clk) begin
      if (Reset) begin
         check("valid", 32'(pif.Pix_valid), 32'(e_valid));
         check("index", 32'(pif.Pix_index), 32'(e_index));
         check("data", 32'(pif.Pix_data), 32'(e_data));
         check("frame_done", 32'(Frame_done), 32'(e_done));
         check("overrun", 32'(Overrun), 32'(e_ovr));
         check("row_error", 32'(Row_error), 32'(e_rerr));
         if (pif.Pix_valid && pif.Pix_ready)
            log_q.push_back(pif.Pix_data);
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic strobe_row(input logic n1, input logic n2,
                             input logic [7:0] a1,
                             input logic [7:0] a2);
      NRE_1 = n1;
      NRE_2 = n2;
      ADC_1_in = a1;
      ADC_2_in = a2;
      ADC = 1'b1;
      tick();
      ADC = 1'b0;
      tick();
      NRE_1 = 1'b1;
      NRE_2 = 1'b1;
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!pif.Pix_valid && n < 40) begin
         tick();
         n++;
      end
      check("wait_valid", 32'(pif.Pix_valid), 32'd1);
   endtask

   task automatic wait_done();
      int n = 0;
      while (!Frame_done && n < 40) begin
         tick();
         n++;
      end
      check("wait_done", 32'(Frame_done), 32'd1);
   endtask

   task automatic check_log(input string name,
                            input logic [31:0] exp);
      logic [31:0] got;
      got = 32'h0;
      check({name, "_len"}, 32'(log_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < log_q.size(); i++)
         got[31-8*i -: 8] = log_q[i];
      check(name, got, exp);
      log_q.delete();
   endtask

   task automatic erase_pulse();
      Erase = 1'b1;
      tick();
      Erase = 1'b0;
      tick();
   endtask

   initial begin
      pif.Pix_ready = 1'b0;
      #12;
      check("rst_valid", 32'(pif.Pix_valid), 32'd0);
      check("rst_data", 32'(pif.Pix_data), 32'd0);
      check("rst_done", 32'(Frame_done), 32'd0);
      @(posedge Clk);
      #1 Reset = 1'b1;
      tick();
      tick();

      // Basic frame, always ready
      pif.Pix_ready = 1'b1;
      log_q.delete();
      strobe_row(1'b0, 1'b1, 8'h11, 8'h22);
      strobe_row(1'b1, 1'b0, 8'h33, 8'h44);
      wait_done();
      check_log("frame1", 32'h11223344);
      tick();
      check("done_pulse", 32'(Frame_done), 32'd0);

      // Backpressure hold for 5 cycles
      pif.Pix_ready = 1'b0;
      strobe_row(1'b0, 1'b1, 8'h11, 8'h22);
      strobe_row(1'b1, 1'b0, 8'h33, 8'h44);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", 32'(pif.Pix_valid), 32'd1);
         check("hold_index", 32'(pif.Pix_index), 32'd0);
         check("hold_data", 32'(pif.Pix_data), 32'h11);
         tick();
      end
      pif.Pix_ready = 1'b1;
      wait_done();
      check_log("frame2", 32'h11223344);

      // Both and neither row enables
      strobe_row(1'b0, 1'b0, 8'h99, 8'h98);
      check("rerr_set", 32'(Row_error), 32'd1);
      strobe_row(1'b1, 1'b1, 8'h97, 8'h96);
      for (int i = 0; i < 4; i++) tick();
      check("rerr_nostream", 32'(pif.Pix_valid), 32'd0);
      erase_pulse();
      check("rerr_clear", 32'(Row_error), 32'd0);

      // Erase beats a same-cycle row-2 strobe
      strobe_row(1'b0, 1'b0, 8'h00, 8'h00);
      strobe_row(1'b0, 1'b1, 8'h5a, 8'h5b);
      NRE_2 = 1'b0;
      ADC = 1'b1;
      tick();
      ADC = 1'b0;
      Erase = 1'b1;
      tick();
      Erase = 1'b0;
      NRE_2 = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("erase_nostream", 32'(pif.Pix_valid), 32'd0);
      check("erase_rerr", 32'(Row_error), 32'd0);

      // New strobe and Erase while streaming
      log_q.delete();
      pif.Pix_ready = 1'b0;
      strobe_row(1'b0, 1'b1, 8'ha1, 8'ha2);
      strobe_row(1'b1, 1'b0, 8'ha3, 8'ha4);
      wait_valid();
      strobe_row(1'b0, 1'b1, 8'hee, 8'hff);
      check("ovr_set", 32'(Overrun), 32'd1);
      erase_pulse();
      check("erase_in_stream", 32'(pif.Pix_valid), 32'd1);
      pif.Pix_ready = 1'b1;
      wait_done();
      check_log("frame_ovr", 32'ha1a2a3a4);
      check("ovr_sticky", 32'(Overrun), 32'd1);
      erase_pulse();
      check("ovr_clear", 32'(Overrun), 32'd0);

      // Reset in the middle of streaming
      strobe_row(1'b0, 1'b1, 8'hc1, 8'hc2);
      strobe_row(1'b1, 1'b0, 8'hc3, 8'hc4);
      begin
         int n = 0;
         while (!(pif.Pix_valid && pif.Pix_index == 2'd2)
                && n < 40) begin
            tick();
            n++;
         end
      end
      check("reach_idx2", 32'(pif.Pix_index), 32'd2);
      #1 Reset = 1'b0;
      #1;
      check("mid_rst_valid", 32'(pif.Pix_valid), 32'd0);
      check("mid_rst_index", 32'(pif.Pix_index), 32'd0);
      check("mid_rst_data", 32'(pif.Pix_data), 32'd0);
      check("mid_rst_ovr", 32'(Overrun), 32'd0);
      @(posedge Clk);
      #1 Reset = 1'b1;
      log_q.delete();
      tick();

      // Fresh frame, row 1 overwritten before completion
      strobe_row(1'b0, 1'b1, 8'h01, 8'h02);
      strobe_row(1'b0, 1'b1, 8'h55, 8'h66);
      strobe_row(1'b1, 1'b0, 8'h77, 8'h88);
      wait_done();
      check_log("frame_after_rst", 32'h55667788);
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
